// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and types for the
// four-port packet switch.
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int OFF_DA    = 0;
  localparam int OFF_LEN   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DROP
  } state_e;

endpackage

// File: rtl/packet_switch_if.sv
// packet_switch_if: write/commit/rollback and
// show-ahead read bus of one output queue.
interface packet_switch_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       commit;
  logic       rollback;
  logic       full;
  logic       rd_en;
  logic       ready;
  logic [7:0] rd_data;

  modport master (
    output wr_en, wr_data, commit, rollback, rd_en,
    input  full, ready, rd_data
  );

  modport slave (
    input  wr_en, wr_data, commit, rollback, rd_en,
    output full, ready, rd_data
  );

endinterface

// File: rtl/switch_port_fifo.sv
// switch_port_fifo: byte queue with a speculative
// write pointer that is published or rewound per packet.
module switch_port_fifo #(
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  packet_switch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] rd_q;
  logic [AW:0] wr_q;
  logic [AW:0] cm_q;
  logic [AW:0] wr_d;
  logic        push;
  logic        pop;
  logic        empty;

  assign bus.full = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty    = (cm_q == rd_q);
  assign push     = bus.wr_en && !bus.full;
  assign pop      = bus.rd_en && !empty;
  assign wr_d     = push ? wr_q + ONE : wr_q;

  assign bus.ready   = !empty;
  assign bus.rd_data = empty ? 8'h00
                             : mem_q[rd_q[AW-1:0]];

  // Storage is written at the speculative pointer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= bus.wr_data;
  end

  // Commit publishes the writer; rollback rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cm_q <= '0;
    end else begin
      if (pop) rd_q <= rd_q + ONE;
      if (bus.rollback) wr_q <= cm_q;
      else              wr_q <= wr_d;
      if (bus.commit) cm_q <= wr_d;
    end
  end

endmodule

// File: rtl/packet_switch.sv
// packet_switch: routes DA/LEN/payload/parity packets
// to four output queues; only good packets become visible.
module packet_switch
  import switch_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       packet_valid,
  input  logic [7:0] data,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic [7:0] data_2,
  output logic [7:0] data_3,
  output logic       ready_0,
  output logic       ready_1,
  output logic       ready_2,
  output logic       ready_3,
  input  logic       read_0,
  input  logic       read_1,
  input  logic       read_2,
  input  logic       read_3,
  input  logic       mem_en,
  input  logic       mem_rd_wr,
  input  logic [1:0] mem_add,
  input  logic [7:0] mem_data
);

  logic [7:0]           cfg_q [NUM_PORTS];
  state_e               state_q;
  logic [1:0]           dst_q;
  logic [7:0]           cnt_q;
  logic [7:0]           par_q;
  logic                 seen_low_q;
  logic                 hit;
  logic [1:0]           dst_c;
  logic [1:0]           tgt;
  logic [NUM_PORTS-1:0] wr_en;
  logic [NUM_PORTS-1:0] commit;
  logic [NUM_PORTS-1:0] rollback;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] rdy;
  logic [NUM_PORTS-1:0] rd_en;
  logic [7:0]           pdata [NUM_PORTS];

  // Address registers; a read access has no effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        cfg_q[i] <= 8'h00;
    end else if (mem_en && mem_rd_wr) begin
      cfg_q[mem_add] <= mem_data;
    end
  end

  // Lowest-index match of the incoming byte as DA.
  always_comb begin
    hit   = 1'b0;
    dst_c = 2'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (data == cfg_q[i]) begin
        hit   = 1'b1;
        dst_c = 2'(i);
      end
    end
  end

  assign tgt = (state_q == ST_IDLE) ? dst_c : dst_q;

  // Per-byte queue strobes for the packet in flight.
  always_comb begin
    wr_en    = '0;
    commit   = '0;
    rollback = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (packet_valid && seen_low_q && hit &&
            !full[tgt])
          wr_en[tgt] = 1'b1;
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (packet_valid && !full[tgt])
          wr_en[tgt] = 1'b1;
        else
          rollback[tgt] = 1'b1;
      end
      ST_PARITY: begin
        if (packet_valid && !full[tgt] &&
            data == par_q) begin
          wr_en[tgt]  = 1'b1;
          commit[tgt] = 1'b1;
        end else begin
          rollback[tgt] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Input framing: DA, LEN, payload, parity or drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dst_q      <= 2'd0;
      cnt_q      <= 8'd0;
      par_q      <= 8'd0;
      seen_low_q <= 1'b0;
    end else begin
      if (!packet_valid) seen_low_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (packet_valid) begin
            if (seen_low_q && hit && !full[dst_c]) begin
              state_q <= ST_HEADER;
              dst_q   <= dst_c;
              par_q   <= data;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_HEADER: begin
          if (!packet_valid) begin
            state_q <= ST_IDLE;
          end else if (full[dst_q]) begin
            state_q <= ST_DROP;
          end else begin
            par_q   <= par_q ^ data;
            cnt_q   <= data;
            state_q <= (data == 8'd0) ? ST_PARITY
                                      : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!packet_valid) begin
            state_q <= ST_IDLE;
          end else if (full[dst_q]) begin
            state_q <= ST_DROP;
          end else begin
            par_q   <= par_q ^ data;
            cnt_q   <= cnt_q - 8'd1;
            state_q <= (cnt_q == 8'd1) ? ST_PARITY
                                       : ST_PAYLOAD;
          end
        end
        ST_PARITY: state_q <= ST_IDLE;
        ST_DROP: begin
          if (!packet_valid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_en = {read_3, read_2, read_1, read_0};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    packet_switch_if bus ();
    assign bus.wr_en    = wr_en[g];
    assign bus.wr_data  = data;
    assign bus.commit   = commit[g];
    assign bus.rollback = rollback[g];
    assign bus.rd_en    = rd_en[g];
    assign full[g]      = bus.full;
    assign rdy[g]       = bus.ready;
    assign pdata[g]     = bus.rd_data;

    switch_port_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clock),
      .rst_n (reset),
      .bus   (bus)
    );
  end

  assign data_0  = pdata[0];
  assign data_1  = pdata[1];
  assign data_2  = pdata[2];
  assign data_3  = pdata[3];
  assign ready_0 = rdy[0];
  assign ready_1 = rdy[1];
  assign ready_2 = rdy[2];
  assign ready_3 = rdy[3];

endmodule

// File: tb/tb_packet_switch.sv
// tb_packet_switch: directed table, corner sequences and
// random traffic against a packet-level queue model.
module tb_packet_switch;
  import switch_pkg::*;

  localparam int DEPTH = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       packet_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] data_0, data_1, data_2, data_3;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic       read_0 = 1'b0, read_1 = 1'b0;
  logic       read_2 = 1'b0, read_3 = 1'b0;
  logic       mem_en = 1'b0, mem_rd_wr = 1'b0;
  logic [1:0] mem_add = 2'd0;
  logic [7:0] mem_data = 8'h00;

  packet_switch #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .packet_valid(packet_valid), .data(data),
    .data_0(data_0), .data_1(data_1),
    .data_2(data_2), .data_3(data_3),
    .ready_0(ready_0), .ready_1(ready_1),
    .ready_2(ready_2), .ready_3(ready_3),
    .read_0(read_0), .read_1(read_1),
    .read_2(read_2), .read_3(read_3),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
    .mem_add(mem_add), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] da;
    int         len;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] flip;
    int         nvalid;
    int         exp_port;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] cfg [4];
  logic [7:0] mq [4][$];
  logic [7:0] pkt [$];
  logic [7:0] last_pop [4];
  int         popped [4];
  logic [3:0] rd_mode = 4'h0;
  bit         rnd_rd = 1'b0;
  int         wr_at = -1;
  logic [1:0] wr_idx = 2'd0;
  logic [7:0] wr_val = 8'h00;
  bit         ok;
  vec_t       tbl [7];

  function automatic logic [3:0] rdy_vec();
    return {ready_3, ready_2, ready_1, ready_0};
  endfunction

  function automatic logic [7:0] dout(input int i);
    case (i)
      0: return data_0;
      1: return data_1;
      2: return data_2;
      default: return data_3;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, wanted %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    logic [3:0] rv;
    logic [3:0] rd;
    bit         want;
    rv = rdy_vec();
    rd = 4'h0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ready_%0d", i),
            32'(rv[i]), 32'(mq[i].size() != 0));
      if (mq[i].size() != 0)
        check($sformatf("data_%0d", i),
              32'(dout(i)), 32'(mq[i][0]));
      else
        check($sformatf("data_%0d_empty", i),
              32'(dout(i)), 32'h0);
      want = rnd_rd ? 1'($urandom_range(0, 1))
                    : rd_mode[i];
      rd[i] = want;
      if (want && mq[i].size() != 0) begin
        last_pop[i] = mq[i].pop_front();
        popped[i]++;
      end
    end
    {read_3, read_2, read_1, read_0} = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic build(input logic [7:0] da,
                       input int len,
                       input logic [7:0] p0,
                       input logic [7:0] p1,
                       input logic [7:0] flip);
    logic [7:0] x;
    pkt.delete();
    pkt.push_back(da);
    pkt.push_back(8'(len));
    for (int k = 0; k < len; k++)
      pkt.push_back(k == 0 ? p0 : k == 1 ? p1
                    : 8'(p0 + p1 * k + k));
    x = 8'h00;
    foreach (pkt[i]) x ^= pkt[i];
    pkt.push_back(x ^ flip);
  endtask

  task automatic send_pkt(input int nvalid,
                          input bit b2b,
                          output bit good);
    int         d;
    int         n;
    bit         found;
    bit         room;
    logic [7:0] x;
    found = 1'b0;
    d     = 0;
    room  = 1'b1;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (cfg[i] == pkt[OFF_DA]) begin
        found = 1'b1;
        d     = i;
      end
    n = (nvalid < pkt.size()) ? nvalid : pkt.size();
    for (int k = 0; k < n; k++) begin
      if (found && (mq[d].size() + k >= DEPTH))
        room = 1'b0;
      packet_valid = 1'b1;
      data         = pkt[k];
      if (k == wr_at) begin
        mem_en = 1'b1; mem_rd_wr = 1'b1;
        mem_add = wr_idx; mem_data = wr_val;
      end
      step();
      if (k == wr_at) begin
        mem_en = 1'b0; mem_rd_wr = 1'b0;
        cfg[wr_idx] = wr_val;
      end
    end
    x = 8'h00;
    foreach (pkt[i]) x ^= pkt[i];
    good = found && room && x == 8'h00 &&
           n == int'(pkt[OFF_LEN]) + 3;
    if (good) foreach (pkt[i]) mq[d].push_back(pkt[i]);
    if (!good || !b2b) begin
      packet_valid = 1'b0;
      data = 8'($urandom);
      step();
    end
    packet_valid = 1'b0;
    wr_at = -1;
  endtask

  task automatic cfg_write(input logic [1:0] idx,
                           input logic [7:0] val);
    packet_valid = 1'b0;
    mem_en = 1'b1; mem_rd_wr = 1'b1;
    mem_add = idx; mem_data = val;
    step();
    mem_en = 1'b0; mem_rd_wr = 1'b0;
    cfg[idx] = val;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_rd = 1'b0;
    rd_mode = 4'hF;
    packet_valid = 1'b0;
    while ((mq[0].size() + mq[1].size() + mq[2].size()
            + mq[3].size()) != 0 && n < 2000) begin
      step();
      n++;
    end
    step();
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: queues not empty");
    end
    rd_mode = 4'h0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p0;
    logic [3:0] ev;
    logic [7:0] da;
    int         len;
    int         nv;

    foreach (cfg[i]) cfg[i] = 8'h00;
    foreach (popped[i]) popped[i] = 0;
    foreach (last_pop[i]) last_pop[i] = 8'h00;

    tbl[0] = '{8'h22, 2,  8'hA5, 8'h5A, 8'h00, 999, 1};
    tbl[1] = '{8'h22, 2,  8'hA5, 8'h5A, 8'h01, 999, -1};
    tbl[2] = '{8'h99, 3,  8'h01, 8'h02, 8'h00, 999, -1};
    tbl[3] = '{8'h33, 10, 8'h10, 8'h20, 8'h00, 4,   -1};
    tbl[4] = '{8'h33, 4,  8'h66, 8'h77, 8'h00, 999, 2};
    tbl[5] = '{8'h11, 0,  8'h00, 8'h00, 8'h00, 999, 0};
    tbl[6] = '{8'h44, 1,  8'hC3, 8'h00, 8'h00, 999, 3};

    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", 32'(rdy_vec()), 32'h0);
    check("reset_data",
          {data_3, data_2, data_1, data_0}, 32'h0);
    reset = 1'b1;
    step();
    step();

    cfg_write(2'd0, 8'h11);
    cfg_write(2'd1, 8'h22);
    cfg_write(2'd2, 8'h33);
    cfg_write(2'd3, 8'h44);

    mem_en = 1'b1; mem_rd_wr = 1'b0;
    mem_add = 2'd1; mem_data = 8'h99;
    step();
    mem_en = 1'b0;

    foreach (tbl[t]) begin
      build(tbl[t].da, tbl[t].len, tbl[t].p0,
            tbl[t].p1, tbl[t].flip);
      p0 = popped[1];
      send_pkt(tbl[t].nvalid, 1'b1, ok);
      ev = (tbl[t].exp_port < 0) ? 4'h0
           : 4'(1 << tbl[t].exp_port);
      check($sformatf("route_%0d", t),
            32'(rdy_vec()), 32'(ev));
      if (tbl[t].exp_port >= 0)
        check($sformatf("head_%0d", t),
              32'(dout(tbl[t].exp_port)),
              32'(tbl[t].da));
      drain();
      if (t == 0) begin
        check("basic_count", popped[1] - p0, 5);
        check("basic_parity",
              32'(last_pop[1]), 32'hDF);
      end
    end

    wr_at = 3; wr_idx = 2'd0; wr_val = 8'h77;
    build(8'h11, 6, 8'h01, 8'h02, 8'h00);
    send_pkt(999, 1'b1, ok);
    check("cfg_mid_pkt", 32'(rdy_vec()), 32'h1);
    drain();
    build(8'h11, 2, 8'h05, 8'h06, 8'h00);
    send_pkt(999, 1'b1, ok);
    check("cfg_after", 32'(rdy_vec()), 32'h0);
    drain();
    cfg_write(2'd0, 8'h11);

    cfg_write(2'd2, 8'h22);
    build(8'h22, 3, 8'h0F, 8'hF0, 8'h00);
    send_pkt(999, 1'b1, ok);
    check("lowest_match", 32'(rdy_vec()), 32'h2);
    drain();
    cfg_write(2'd2, 8'h33);

    build(8'h11, 100, 8'h01, 8'h03, 8'h00);
    send_pkt(999, 1'b0, ok);
    check("ovf_drop", 32'(rdy_vec()), 32'h0);
    p0 = popped[0];
    rd_mode = 4'h1;
    for (int i = 0; i < 20; i++) begin
      build(8'h11, 5, 8'(i), 8'(i * 3), 8'h00);
      send_pkt(999, 1'b1, ok);
    end
    drain();
    check("b2b_count", popped[0] - p0, 160);

    rnd_rd = 1'b1;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: cfg_write(2'($urandom_range(0, 3)), 8'h11);
          1: cfg_write(2'($urandom_range(0, 3)), 8'h22);
          2: cfg_write(2'($urandom_range(0, 3)), 8'h33);
          3: cfg_write(2'($urandom_range(0, 3)), 8'h44);
          default: cfg_write(2'($urandom_range(0, 3)),
                             8'($urandom));
        endcase
      end
      da  = ($urandom_range(0, 3) != 0)
            ? cfg[$urandom_range(0, 3)] : 8'($urandom);
      len = ($urandom_range(0, 9) == 0)
            ? $urandom_range(40, 80)
            : $urandom_range(0, 12);
      build(da, len, 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0)
            ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      nv = ($urandom_range(0, 9) == 0)
           ? $urandom_range(1, len + 2) : 999;
      send_pkt(nv, 1'($urandom_range(0, 1)), ok);
    end
    drain();

    cfg_write(2'd0, 8'h11);
    cfg_write(2'd1, 8'h22);
    cfg_write(2'd2, 8'h33);
    cfg_write(2'd3, 8'h44);
    build(8'h44, 1, 8'h3C, 8'h00, 8'h00);
    send_pkt(999, 1'b1, ok);
    check("pre_rst_p3", 32'(rdy_vec()), 32'h8);
    build(8'h22, 8, 8'h10, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
      packet_valid = 1'b1;
      data = pkt[k];
      step();
    end
    #2 reset = 1'b0;
    #1;
    check("rst_ready", 32'(rdy_vec()), 32'h0);
    check("rst_data",
          {data_3, data_2, data_1, data_0}, 32'h0);
    foreach (mq[i]) mq[i].delete();
    foreach (cfg[i]) cfg[i] = 8'h00;
    packet_valid = 1'b1;
    data = 8'h00;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    step();
    packet_valid = 1'b0;
    step();
    build(8'h00, 2, 8'h5C, 8'hC5, 8'h00);
    send_pkt(999, 1'b1, ok);
    check("rst_route0", 32'(rdy_vec()), 32'h1);
    drain();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_switch.md
PACKET_SWITCH -- requirements
Module: packet_switch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, meaning bytes of storage per output port (power of two, at least 4).
REQ-002 SHALL have port clock, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port packet_valid, input, 1 bit: high for every byte of an incoming packet.
REQ-005 SHALL have port data, input, 8 bits: incoming packet byte.
REQ-006 SHALL have ports data_0..data_3, output, 8 bits each: head byte of output port i.
REQ-007 SHALL have ports ready_0..ready_3, output, 1 bit each: port i holds at least one committed byte.
REQ-008 SHALL have ports read_0..read_3, input, 1 bit each: pop one byte from port i.
REQ-009 SHALL have port mem_en, input, 1 bit: config access enable.
REQ-010 SHALL have port mem_rd_wr, input, 1 bit: 1 = write, 0 = read (no effect).
REQ-011 SHALL have port mem_add, input, 2 bits: config register index, which equals the port number.
REQ-012 SHALL have port mem_data, input, 8 bits: config write data, the port address.

Function
REQ-013 SHALL define the packet format as: byte0 DA, byte1 LEN (0..255), LEN payload bytes, then one parity byte; total LEN+3 bytes.
REQ-014 SHALL set parity so that it equals the XOR of all preceding bytes of the packet.
REQ-015 SHALL sample packet_valid and data on each rising clock edge; the first valid byte after idle is DA.
REQ-016 SHALL write config register mem[mem_add] = mem_data on an edge where mem_en=1 and mem_rd_wr=1.
REQ-017 SHALL compare DA, latched at byte0, against mem[0..3]; the lowest matching index is the destination; if no index matches, the packet is dropped.
REQ-018 SHALL apply config writes during a packet only to later packets.
REQ-019 SHALL use input FSM states IDLE, HEADER (LEN), PAYLOAD, PARITY, and DROP (consume until packet_valid=0).
REQ-020 SHALL write every byte, DA through parity, into the destination FIFO as it arrives; these bytes remain uncommitted until the packet completes.
REQ-021 SHALL commit the packet on the edge that samples the parity byte if parity is correct; ready_i SHALL be high in the following cycle.
REQ-022 SHALL discard the whole packet by rolling back the write pointer on any of these errors: parity mismatch, packet_valid low before the parity byte, or FIFO full before the parity byte. No partial packet SHALL ever be visible.
REQ-023 SHALL treat packet_valid still high after the parity byte as a new packet's DA.
REQ-024 SHALL drive data_i combinationally from the committed head byte (show-ahead), or 0x00 when empty.
REQ-025 SHALL pop one byte when read_i=1 and ready_i=1 at a rising edge; read_i while empty SHALL be ignored.
REQ-026 SHALL allow a simultaneous write and pop on the same FIFO, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 SHALL operate the four output ports independently of each other and of the input side.

Reset
REQ-028 SHALL, while reset=0: clear all FIFOs, set mem[0..3]=0x00, force ready_i=0 and data_i=0x00, and put the FSM in IDLE.
REQ-029 SHALL discard any in-flight packet when reset is asserted mid-packet; after release, a packet_valid already high SHALL be consumed in DROP until it falls.

Structure
REQ-030 SHALL place NUM_PORTS=4, the FSM state enum, and the header byte offsets in shared package switch_pkg.
REQ-031 SHALL implement each output queue as one instance of sub-module switch_port_fifo (commit/rollback write pointer, show-ahead read); there are 4 instances.

Verification
REQ-032 SHALL verify basic routing: config mem=0x11,0x22,0x33,0x44; send DA=0x22, LEN=2, payload 0xA5,0x5A, correct parity -> ready_1=1 one cycle after parity; reading 5 bytes returns 0x22,0x02,0xA5,0x5A,parity; ready_1 then 0.
REQ-033 SHALL verify parity error: same packet with parity XOR 0x01 -> ready_1 stays 0 and the FIFO is empty.
REQ-034 SHALL verify unknown destination: DA=0x99 -> all ready_i stay 0.
REQ-035 SHALL verify early abort: DA=0x33, LEN=10, packet_valid low after 4 bytes -> ready_2 stays 0; the next good packet to 0x33 is delivered intact.
REQ-036 SHALL verify overflow and wrap: FIFO_DEPTH=64; a LEN=100 packet to port 0 is dropped; 20 back-to-back LEN=5 packets to port 0 with concurrent reads are all delivered in order.
REQ-037 SHALL verify reset mid-packet: reset=0 during the payload -> ready_i=0 and data_i=0x00 immediately; mem reads back as 0, so DA=0x00 then routes to port 0.
